mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-port 32-bit memory between the instruction-fetch path and the data-memory path of the rv32i core. It sits between the core (fetch unit, load/store unit) and the unified memory array. It serialises their accesses with a req/gnt handshake, uses round-robin priority, and returns read data to the correct owner one cycle later.

## Interface
Parameters:
- ADDR_W, 5, word address width, shared by both requesters and the memory port
- DATA_W, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  data read data valid (reads only)
- dm_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after a read strobe

## Operation
- Each requester holds req and its payload stable until it sees gnt high. gnt is a single-cycle pulse. req may drop the cycle after gnt, or stay high to request again.
- The arbiter makes at most one grant per cycle. The grant is combinational from the req inputs and the priority register. The memory command (mem_en, mem_we, mem_addr, mem_wdata) is driven in the same cycle from the granted requester.
- Priority: a 1-bit register `last` records the last granted owner (0 = IF, 1 = DM).
  - If only one requester is active, it is granted.
  - If both are active, the requester that was not granted last is granted.
  - `last` resets to IF, so DM wins the first conflict.
- Read tracking: registered `pend_valid` and `pend_owner` capture each granted read.
  - One cycle later, the owner's rvalid goes high with rdata = mem_rdata.
  - The other requester's rvalid is 0 and its rdata holds its last value.
- Writes produce only gnt, never rvalid.
- With no requests: mem_en = 0 and mem_we = 0. mem_addr and mem_wdata are don't-care but driven to 0.
- A new grant is allowed in the same cycle a previous read's rvalid is presented, giving full back-to-back throughput.

## Timing
- Reset (rst low, asynchronous): last = IF, pend_valid = 0, if_rvalid = dm_rvalid = 0, if_rdata = dm_rdata = 0.
  - gnt and mem_* are combinational, but forced to 0 while rst is low.
- Read latency: gnt in cycle N, rvalid and rdata in cycle N+1.
- Write: committed by the memory at the rising edge ending cycle N.
- Simultaneous requests: exactly one gnt. The loser keeps req high and is granted in cycle N+1 if the winner does not re-request. If the winner does re-request, round-robin still grants the loser in N+1.
- Reset asserted mid-read: the pending rvalid is dropped and no rvalid is issued after reset release.
- Reset release: the first grant is possible in the first cycle rst is high.

## Structure
- A shared package `rv32i_mem_pkg` holds ADDR_W, DATA_W and the owner encoding constants OWN_IF = 0 and OWN_DM = 1. The memory array and the core include the same package.
- One sub-module: `rr_arb2`, a two-way round-robin arbiter with the `last` register inside. Its ports are clk, rst, req[1:0], gnt[1:0].
- The top level holds the command mux, the pend_valid/pend_owner register and the rdata steering.

## Test plan
- Reset, then if_req = 1 at addr 3 (mem[3] = 0x00000013) -> if_gnt in cycle 0, if_rvalid = 1 with if_rdata = 0x00000013 in cycle 1, dm_rvalid = 0.
- dm_req write addr 7 data 0xDEADBEEF, then dm read addr 7 -> two dm_gnt pulses, mem_we = 1 only on the first, dm_rvalid with 0xDEADBEEF exactly one cycle after the second grant.
- if_req and dm_req both held high for 6 cycles (all reads) -> grants alternate DM, IF, DM, IF, DM, IF, each rvalid goes only to the matching owner, and mem_en is high every cycle.
- dm write granted while if_req is pending -> IF granted the next cycle, and no rvalid is generated for the write.
- rst pulled low in the cycle after an IF read grant -> if_rvalid stays 0 through and after reset, and a later DM-only request is granted on the first cycle after release.
- Idle for 10 cycles -> mem_en = 0, mem_we = 0, both gnt = 0, both rvalid = 0.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared memory-system definitions for the rv32i core, the arbiter and the
// unified memory array.
package rv32i_mem_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   typedef struct packed {
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_arbiter.
interface mem_arbiter_if
   import rv32i_mem_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
);

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [DW-1:0] dm_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is IF, bit 1 is DM. Grants are
// combinational and suppressed while rst is low.
module rr_arb2
   import rv32i_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_q, last_d;
   logic [1:0] gnt_c;

   always_comb begin
      gnt_c = 2'b00;
      case (req)
         2'b01:   gnt_c = 2'b01;
         2'b10:   gnt_c = 2'b10;
         // On conflict the owner not served last wins
         2'b11:   gnt_c = (last_q == OWN_IF) ? 2'b10 : 2'b01;
         default: gnt_c = 2'b00;
      endcase
      if (!rst) gnt_c = 2'b00;

      last_d = last_q;
      if (gnt_c[OWN_DM])      last_d = OWN_DM;
      else if (gnt_c[OWN_IF]) last_d = OWN_IF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_q <= OWN_IF;
      else      last_q <= last_d;
   end

   assign gnt = gnt_c;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// steering each read's data back to its owner one cycle after the grant.
module mem_arbiter
   import rv32i_mem_pkg::*;
#(
   parameter int ADDR_W = rv32i_mem_pkg::ADDR_W,
   parameter int DATA_W = rv32i_mem_pkg::DATA_W
)(
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   logic [1:0]        gnt;
   logic              cmd_en, cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              pend_valid_q, pend_valid_d;
   logic              pend_owner_q, pend_owner_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_rvalid, dm_rvalid;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({bus.dm_req, bus.if_req}),
      .gnt (gnt)
   );

   always_comb begin
      cmd_en    = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      if (gnt[OWN_DM]) begin
         cmd_en    = 1'b1;
         cmd_we    = bus.dm_we;
         cmd_addr  = bus.dm_addr;
         cmd_wdata = bus.dm_wdata;
      end else if (gnt[OWN_IF]) begin
         cmd_en    = 1'b1;
         cmd_addr  = bus.if_addr;
      end
   end

   assign bus.if_gnt    = gnt[OWN_IF];
   assign bus.dm_gnt    = gnt[OWN_DM];
   assign bus.mem_en    = cmd_en;
   assign bus.mem_we    = cmd_we;
   assign bus.mem_addr  = cmd_addr;
   assign bus.mem_wdata = cmd_wdata;

   // Writes never return data, so only granted reads become pending
   always_comb begin
      pend_valid_d = gnt[OWN_IF] | (gnt[OWN_DM] & ~bus.dm_we);
      pend_owner_d = gnt[OWN_DM] ? OWN_DM : OWN_IF;
   end

   assign if_rvalid = pend_valid_q & (pend_owner_q == OWN_IF);
   assign dm_rvalid = pend_valid_q & (pend_owner_q == OWN_DM);

   // The non-owner's rdata keeps showing the last word it received
   always_comb begin
      if_rdata_d = if_rvalid ? bus.mem_rdata : if_rdata_q;
      dm_rdata_d = dm_rvalid ? bus.mem_rdata : dm_rdata_q;
   end

   assign bus.if_rvalid = if_rvalid;
   assign bus.dm_rvalid = dm_rvalid;
   assign bus.if_rdata  = if_rdata_d;
   assign bus.dm_rdata  = dm_rdata_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid_q <= 1'b0;
         pend_owner_q <= OWN_IF;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_owner_q <= pend_owner_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level
// reference model with its own copy of the memory contents.
module tb_mem_arbiter;
   import rv32i_mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

   function automatic logic [31:0] init_word(input logic [4:0] a);
      return (a == 5'd3) ? 32'h0000_0013 : (32'hA500_0000 | {19'b0, a, 8'h00} | {27'b0, a});
   endfunction

   // Memory array seen by the DUT
   logic [31:0] mem [32];
   logic [31:0] wr_flag = '0;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            wr_flag[bus.mem_addr] <= 1'b1;
         end else begin
            bus.mem_rdata <= wr_flag[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   logic [31:0] ref_mem [32];
   int          last_own;         // 0 = IF, 1 = DM
   bit          exp_pv;
   int          exp_po;
   logic [31:0] exp_pdata;
   logic [31:0] if_hold, dm_hold;
   int          win;              // 0 none, 1 IF, 2 DM

   task automatic model_reset();
      last_own = 0;
      exp_pv   = 0;
      if_hold  = '0;
      dm_hold  = '0;
   endtask

   // One clock cycle: check outputs mid-cycle, advance model, move past edge
   task automatic step();
      bit e_ifv, e_dmv;
      @(negedge clk);
      if (bus.if_req && bus.dm_req) win = (last_own == 0) ? 2 : 1;
      else if (bus.dm_req)          win = 2;
      else if (bus.if_req)          win = 1;
      else                          win = 0;

      chk("if_gnt", bus.if_gnt, win == 1);
      chk("dm_gnt", bus.dm_gnt, win == 2);
      chk("mem_en", bus.mem_en, win != 0);
      chk("mem_we", bus.mem_we, (win == 2) && bus.dm_we);
      chk("mem_addr", bus.mem_addr, (win == 2) ? bus.dm_addr : (win == 1) ? bus.if_addr : 5'd0);
      chk("mem_wdata", bus.mem_wdata, (win == 2) ? bus.dm_wdata : 32'd0);

      e_ifv = exp_pv && exp_po == 0;
      e_dmv = exp_pv && exp_po == 1;
      chk("if_rvalid", bus.if_rvalid, e_ifv);
      chk("dm_rvalid", bus.dm_rvalid, e_dmv);
      chk("if_rdata", bus.if_rdata, e_ifv ? exp_pdata : if_hold);
      chk("dm_rdata", bus.dm_rdata, e_dmv ? exp_pdata : dm_hold);
      if (e_ifv) if_hold = exp_pdata;
      if (e_dmv) dm_hold = exp_pdata;

      exp_pv = (win == 1) || (win == 2 && !bus.dm_we);
      exp_po = (win == 2) ? 1 : 0;
      if (win == 1) exp_pdata = ref_mem[bus.if_addr];
      if (win == 2 && !bus.dm_we) exp_pdata = ref_mem[bus.dm_addr];
      if (win == 2 && bus.dm_we) ref_mem[bus.dm_addr] = bus.dm_wdata;
      if (win != 0) last_own = win - 1;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      chk("rst_if_gnt", bus.if_gnt, 1'b0);
      chk("rst_dm_gnt", bus.dm_gnt, 1'b0);
      chk("rst_mem_en", bus.mem_en, 1'b0);
      chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
      chk("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_if_rvalid", bus.if_rvalid, 1'b0);
      model_reset();
      rst = 1'b1;
   endtask

   task automatic drive(input bit ir, input logic [4:0] ia, input bit dr, input bit dw,
                        input logic [4:0] da, input logic [31:0] dd);
      bus.if_req = ir; bus.if_addr = ia;
      bus.dm_req = dr; bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dd;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = init_word(5'(i));
      model_reset();
      drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'd0);
      @(posedge clk);
      #1;
      apply_reset();

      // Single fetch read of address 3
      drive(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("t1_if_gnt", bus.if_gnt, 1'b1);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("t1_if_rvalid", bus.if_rvalid, 1'b1);
      chk("t1_if_rdata", bus.if_rdata, 32'h0000_0013);
      chk("t1_dm_rvalid", bus.dm_rvalid, 1'b0);
      step();

      // Data write then read back of address 7
      drive(1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
      #1 chk("t2_wr_we", bus.mem_we, 1'b1);
      step();
      drive(1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 32'd0);
      #1 chk("t2_rd_we", bus.mem_we, 1'b0);
      chk("t2_rd_gnt", bus.dm_gnt, 1'b1);
      chk("t2_wr_no_rvalid", bus.dm_rvalid, 1'b0);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("t2_dm_rvalid", bus.dm_rvalid, 1'b1);
      chk("t2_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
      step();

      // Sustained conflict after reset: DM, IF, DM, IF, ...
      apply_reset();
      drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'd0);
      for (int i = 0; i < 6; i++) begin
         #1 chk("t3_dm_gnt", bus.dm_gnt, (i % 2) == 0);
         chk("t3_mem_en", bus.mem_en, 1'b1);
         step();
      end
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      step();

      // DM write wins while IF waits; IF follows, no rvalid for the write
      drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd9, 32'h1234_5678);
      #1 chk("t4_dm_gnt", bus.dm_gnt, 1'b1);
      step();
      drive(1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("t4_if_gnt", bus.if_gnt, 1'b1);
      chk("t4_dm_rvalid", bus.dm_rvalid, 1'b0);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      step();

      // Reset lands while an IF read is pending
      drive(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      apply_reset();
      drive(1'b0, 5'd0, 1'b1, 1'b0, 5'd9, 32'd0);
      #1 chk("t5_first_gnt", bus.dm_gnt, 1'b1);
      chk("t5_if_rvalid", bus.if_rvalid, 1'b0);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      step();

      // Idle
      for (int i = 0; i < 10; i++) step();

      // Randomised traffic; requesters hold until granted
      for (int i = 0; i < 400; i++) begin
         step();
         if (!bus.if_req || win == 1) begin
            bus.if_req  = ($urandom_range(0, 99) < 60);
            bus.if_addr = 5'($urandom_range(0, 31));
         end
         if (!bus.dm_req || win == 2) begin
            bus.dm_req   = ($urandom_range(0, 99) < 60);
            bus.dm_we    = ($urandom_range(0, 99) < 40);
            bus.dm_addr  = 5'($urandom_range(0, 31));
            bus.dm_wdata = $urandom;
         end
      end
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
